buffer_mem_arbiter: RTL and testbench

N_CH-requestor arbiter in front of one single-port buffer SRAM (input, weight, output or psum buffer). It generalises the fixed external-vs-controller mux on each buffer.
- Adds selectable arbitration modes, per-channel valid/ready handshake and read-response routing with a configurable memory latency.
- Adds out-of-range address detection and a stall counter for bench and BIST visibility.
- Sits between the matrix-mult controller, the external host port, the BIST engine and each buffer memory.

---
 rtl/buffer_mem_arbiter_if.sv | 23 ++
 rtl/buffer_mem_arbiter.sv | 96 +++++++++
 tb/tb_buffer_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_mem_arbiter_if.sv
// buffer_mem_arbiter_if: per-channel request/response bus between the requestors and the buffer arbiter.
interface buffer_mem_arbiter_if #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 9,
  parameter int DW     = 32
) ();
  logic [N_CH-1:0]        req_valid_i;
  logic [N_CH-1:0]        req_ready_o;
  logic [N_CH-1:0]        req_wen_i;
  logic [N_CH*ADDR_W-1:0] req_addr_i;
  logic [N_CH*DW-1:0]     req_data_i;
  logic [N_CH-1:0]        rsp_valid_o;
  logic [DW-1:0]          rsp_data_o;
  logic                   rsp_err_o;
  modport master (
    output req_valid_i, req_wen_i, req_addr_i, req_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );
  modport slave (
    input  req_valid_i, req_wen_i, req_addr_i, req_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/buffer_mem_arbiter.sv
// buffer_mem_arbiter: N_CH-requestor arbiter in front of one single-port buffer SRAM with latency-matched read routing.
module buffer_mem_arbiter #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int SIZE    = 512,
  parameter int N_CH    = 3,
  parameter int MEM_LAT = 1,
  localparam int DW     = WIDTH * LANES,
  localparam int ADDR_W = $clog2(SIZE),
  localparam int CW     = $clog2(N_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        mode_i,
  input  logic [CW-1:0]     lock_ch_i,
  buffer_mem_arbiter_if.slave bus,
  output logic              mem_cenb_o,
  output logic              mem_wenb_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DW-1:0]     mem_d_o,
  input  logic [DW-1:0]     mem_q_i,
  output logic              err_o,
  output logic [15:0]       stall_cnt_o
);
  logic [CW-1:0]     cand [N_CH];
  logic [ADDR_W-1:0] addr_a [N_CH];
  logic [DW-1:0]     data_a [N_CH];
  logic              gnt_v, hit, oor, acc, wr;
  logic [CW-1:0]     gnt_ch, rr_q, rr_d;
  logic              cenb_q, wenb_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]     d_q;
  logic [15:0]       stall_q;
  logic [MEM_LAT:0]  pv_q, pe_q;
  logic [CW-1:0]     pc_q [MEM_LAT+1];
  // cand[i] is the i-th channel in priority order for the current mode
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign cand[g]   = mode_i == 2'd1 ? CW'((int'(rr_q) + g) % N_CH) : CW'(g);
    assign addr_a[g] = bus.req_addr_i[g*ADDR_W +: ADDR_W];
    assign data_a[g] = bus.req_data_i[g*DW +: DW];
  end
  always_comb begin
    gnt_v  = 1'b0;
    gnt_ch = '0;
    if (mode_i == 2'd2) begin
      gnt_v  = int'(lock_ch_i) < N_CH && bus.req_valid_i[lock_ch_i];
      gnt_ch = lock_ch_i;
    end else
      for (int i = N_CH - 1; i >= 0; i--)
        if (bus.req_valid_i[cand[i]]) begin
          gnt_v  = 1'b1;
          gnt_ch = cand[i];
        end
  end
  assign hit = gnt_v & ~rst_i;
  assign oor = {1'b0, addr_a[gnt_ch]} >= (ADDR_W+1)'(SIZE);
  assign acc = hit & ~oor;
  assign wr  = bus.req_wen_i[gnt_ch];
  assign rr_d = gnt_ch == CW'(N_CH - 1) ? '0 : gnt_ch + CW'(1);
  assign bus.req_ready_o = hit ? N_CH'(1) << gnt_ch : '0;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      cenb_q  <= 1'b1;
      wenb_q  <= 1'b1;
      addr_q  <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      rr_q    <= '0;
      pv_q    <= '0;
      pe_q    <= '0;
      for (int k = 0; k <= MEM_LAT; k++) pc_q[k] <= '0;
    end else begin
      cenb_q <= ~acc;
      wenb_q <= ~(acc & wr);
      if (acc) addr_q <= addr_a[gnt_ch];
      if (acc & wr) d_q <= data_a[gnt_ch];
      err_q <= err_q | (hit & oor);
      if (|(bus.req_valid_i & ~bus.req_ready_o) && ~&stall_q) stall_q <= stall_q + 16'd1;
      if (hit && mode_i == 2'd1) rr_q <= rr_d;
      pv_q    <= {pv_q[MEM_LAT-1:0], hit & ~wr};
      pe_q    <= {pe_q[MEM_LAT-1:0], oor};
      pc_q[0] <= gnt_ch;
      for (int k = 1; k <= MEM_LAT; k++) pc_q[k] <= pc_q[k-1];
    end
  assign mem_cenb_o  = cenb_q;
  assign mem_wenb_o  = wenb_q;
  assign mem_addr_o  = addr_q;
  assign mem_d_o     = d_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_q;
  // out-of-range reads never touched the SRAM, so their data is forced to zero
  assign bus.rsp_valid_o = pv_q[MEM_LAT] ? N_CH'(1) << pc_q[MEM_LAT] : '0;
  assign bus.rsp_err_o   = pv_q[MEM_LAT] & pe_q[MEM_LAT];
  assign bus.rsp_data_o  = pv_q[MEM_LAT] & ~pe_q[MEM_LAT] ? mem_q_i : '0;
endmodule

// File: tb/tb_buffer_mem_arbiter.sv
// tb_buffer_mem_arbiter: table, directed and randomized checks of buffer_mem_arbiter against a queue-based model.
module tb_buffer_mem_arbiter;
  localparam int N = 3;
  logic clk = 1'b0, rst = 1'b1, mem_clr = 1'b1;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic [1:0] mode_a = '0, mode_b = '0, lock_a = '0, lock_b = '0;
  logic cenb_a, wenb_a, err_a, cenb_b, wenb_b, err_b;
  logic [8:0] addr_a, addr_b;
  logic [31:0] d_a, d_b, q_a, q_b1, q_b2, q_b3;
  logic [15:0] stall_a, stall_b;
  logic [31:0] mem_a [512];
  logic [31:0] mem_b [512];

  buffer_mem_arbiter_if #(.N_CH(N), .ADDR_W(9), .DW(32)) ia ();
  buffer_mem_arbiter_if #(.N_CH(N), .ADDR_W(9), .DW(32)) ib ();

  buffer_mem_arbiter dut_a (
    .clk_i(clk), .rst_i(rst), .mode_i(mode_a), .lock_ch_i(lock_a), .bus(ia),
    .mem_cenb_o(cenb_a), .mem_wenb_o(wenb_a), .mem_addr_o(addr_a), .mem_d_o(d_a),
    .mem_q_i(q_a), .err_o(err_a), .stall_cnt_o(stall_a));

  buffer_mem_arbiter #(.SIZE(500), .MEM_LAT(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .mode_i(mode_b), .lock_ch_i(lock_b), .bus(ib),
    .mem_cenb_o(cenb_b), .mem_wenb_o(wenb_b), .mem_addr_o(addr_b), .mem_d_o(d_b),
    .mem_q_i(q_b3), .err_o(err_b), .stall_cnt_o(stall_b));

  // SRAM models: A has 1-cycle read latency, B has 3
  always @(posedge clk)
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
      q_a  <= '0;
      q_b1 <= '0;
      q_b2 <= '0;
      q_b3 <= '0;
    end else begin
      if (!cenb_a && !wenb_a) mem_a[addr_a] <= d_a;
      if (!cenb_a && wenb_a) q_a <= mem_a[addr_a];
      if (!cenb_b && !wenb_b) mem_b[addr_b] <= d_b;
      q_b1 <= (!cenb_b && wenb_b) ? mem_b[addr_b] : '0;
      q_b2 <= q_b1;
      q_b3 <= q_b2;
    end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic put_a(input int ch, input logic v, input logic w, input logic [8:0] a, input logic [31:0] d);
    ia.req_valid_i[ch] = v;
    ia.req_wen_i[ch] = w;
    ia.req_addr_i[ch*9 +: 9] = a;
    ia.req_data_i[ch*32 +: 32] = d;
  endtask

  task automatic put_b(input int ch, input logic v, input logic w, input logic [8:0] a, input logic [31:0] d);
    ib.req_valid_i[ch] = v;
    ib.req_wen_i[ch] = w;
    ib.req_addr_i[ch*9 +: 9] = a;
    ib.req_data_i[ch*32 +: 32] = d;
  endtask

  task automatic idle();
    ia.req_valid_i = '0; ia.req_wen_i = '0; ia.req_addr_i = '0; ia.req_data_i = '0;
    ib.req_valid_i = '0; ib.req_wen_i = '0; ib.req_addr_i = '0; ib.req_data_i = '0;
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1;
    idle();
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  function automatic int rank(input int c, input int md, input int p);
    return md == 1 ? (c - p + N) % N : c;
  endfunction

  typedef struct { logic [1:0] mode; logic [1:0] lock; logic [2:0] valid; logic [2:0] ready; } vec_t;
  typedef struct { int due; int ch; logic [31:0] data; } rsp_t;
  vec_t tbl [12];
  rsp_t rq [$];
  logic [31:0] ref_mem [16];
  bit pv [N];
  bit pw [N];
  logic [8:0] pa [N];
  logic [31:0] pd [N];
  int ptr, stall_m, win, m, lk;
  bit prev, st;

  initial begin
    tbl = '{
      '{2'd0, 2'd0, 3'b000, 3'b000}, '{2'd0, 2'd0, 3'b110, 3'b010},
      '{2'd0, 2'd0, 3'b101, 3'b001}, '{2'd3, 2'd0, 3'b110, 3'b010},
      '{2'd3, 2'd1, 3'b100, 3'b100}, '{2'd2, 2'd1, 3'b011, 3'b010},
      '{2'd2, 2'd1, 3'b101, 3'b000}, '{2'd2, 2'd2, 3'b111, 3'b100},
      '{2'd2, 2'd3, 3'b111, 3'b000}, '{2'd2, 2'd0, 3'b001, 3'b001},
      '{2'd0, 2'd2, 3'b100, 3'b100}, '{2'd3, 2'd2, 3'b111, 3'b001}};
    idle();
    ia.req_valid_i = 3'b111;
    nxt();
    mem_clr = 1'b0;
    smp();
    chk("rst_ready", ia.req_ready_o, 0);
    chk("rst_cenb", cenb_a, 1);
    chk("rst_wenb", wenb_a, 1);
    chk("rst_addr", addr_a, 0);
    chk("rst_d", d_a, 0);
    chk("rst_rsp_valid", ia.rsp_valid_o, 0);
    chk("rst_rsp_err", ia.rsp_err_o, 0);
    chk("rst_err", err_a, 0);
    chk("rst_stall", stall_a, 0);
    do_reset();

    foreach (tbl[i]) begin
      nxt();
      mode_a = tbl[i].mode;
      lock_a = tbl[i].lock;
      ia.req_valid_i = tbl[i].valid;
      smp();
      chk("table_ready", ia.req_ready_o, tbl[i].ready);
    end
    mode_a = 2'd0;
    lock_a = 2'd0;
    do_reset();

    nxt();
    put_a(1, 1, 1, 9'd5, 32'h11223344);
    smp();
    chk("wr_ready", ia.req_ready_o, 3'b010);
    nxt();
    put_a(1, 1, 0, 9'd5, 32'h0);
    smp();
    chk("wr_cenb", cenb_a, 0);
    chk("wr_wenb", wenb_a, 0);
    chk("wr_addr", addr_a, 5);
    chk("wr_data", d_a, 32'h11223344);
    chk("rd_ready", ia.req_ready_o, 3'b010);
    nxt();
    idle();
    smp();
    chk("rd_cenb", cenb_a, 0);
    chk("rd_wenb", wenb_a, 1);
    chk("rd_early", ia.rsp_valid_o, 0);
    nxt();
    smp();
    chk("rd_rsp_valid", ia.rsp_valid_o, 3'b010);
    chk("rd_rsp_data", ia.rsp_data_o, 32'h11223344);
    chk("rd_rsp_err", ia.rsp_err_o, 0);
    chk("rd_idle_cenb", cenb_a, 1);

    do_reset();
    for (int k = 0; k < 3; k++) begin
      nxt();
      put_a(0, 1, 0, 9'(10 + k), 0);
      put_a(1, 1, 0, 9'd20, 0);
      put_a(2, 1, 0, 9'd21, 0);
      smp();
      chk("fixed_ready", ia.req_ready_o, 3'b001);
    end
    nxt();
    idle();
    smp();
    chk("fixed_stall", stall_a, 3);

    do_reset();
    mode_a = 2'd1;
    for (int k = 0; k < 6; k++) begin
      nxt();
      for (int c = 0; c < N; c++) put_a(c, 1, 0, 9'(k), 0);
      smp();
      chk("rr_ready", ia.req_ready_o, 1 << (k % 3));
      if (k > 0) chk("rr_cenb", cenb_a, 0);
    end
    nxt();
    idle();
    smp();
    chk("rr_cenb_last", cenb_a, 0);

    do_reset();
    nxt();
    mode_a = 2'd2;
    lock_a = 2'd2;
    put_a(0, 1, 0, 9'd7, 0);
    put_a(2, 1, 0, 9'd5, 0);
    smp();
    chk("lock_ready", ia.req_ready_o, 3'b100);
    nxt();
    mode_a = 2'd0;
    put_a(2, 0, 0, 9'd0, 0);
    smp();
    chk("lock_switch_ready", ia.req_ready_o, 3'b001);
    nxt();
    idle();
    smp();
    chk("lock_rsp_valid", ia.rsp_valid_o, 3'b100);
    chk("lock_rsp_data", ia.rsp_data_o, 32'h11223344);
    nxt();
    smp();
    chk("switch_rsp_valid", ia.rsp_valid_o, 3'b001);
    chk("switch_rsp_data", ia.rsp_data_o, 0);

    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_mem[5] = 32'h11223344;
    do_reset();
    mode_a = 2'd0;
    ptr = 0;
    stall_m = 0;
    prev = 1'b0;
    for (int n = 0; n < 400; n++) begin
      nxt();
      if ($urandom_range(0, 15) == 0) begin
        mode_a = 2'($urandom_range(0, 3));
        lock_a = 2'($urandom_range(0, 3));
      end
      for (int c = 0; c < N; c++) begin
        if (!pv[c] && $urandom_range(0, 2) != 0) begin
          pv[c] = 1'b1;
          pw[c] = 1'($urandom_range(0, 1));
          pa[c] = 9'($urandom_range(0, 15));
          pd[c] = $urandom;
        end
        put_a(c, pv[c], pw[c], pa[c], pd[c]);
      end
      m = int'(mode_a);
      lk = int'(lock_a);
      win = -1;
      if (m == 2) begin
        if (lk < N && pv[lk]) win = lk;
      end else
        for (int c = 0; c < N; c++)
          if (pv[c] && (win < 0 || rank(c, m, ptr) < rank(win, m, ptr))) win = c;
      smp();
      chk("rand_ready", ia.req_ready_o, win < 0 ? 0 : 1 << win);
      chk("rand_cenb", cenb_a, !prev);
      chk("rand_stall", stall_a, stall_m);
      if (rq.size() > 0 && rq[0].due == n) begin
        chk("rand_rsp_valid", ia.rsp_valid_o, 1 << rq[0].ch);
        chk("rand_rsp_data", ia.rsp_data_o, rq[0].data);
        void'(rq.pop_front());
      end else
        chk("rand_rsp_idle", {ia.rsp_valid_o, ia.rsp_data_o}, 0);
      st = 1'b0;
      for (int c = 0; c < N; c++) st |= pv[c] && c != win;
      if (st && stall_m < 65535) stall_m++;
      prev = win >= 0;
      if (win >= 0) begin
        if (pw[win]) ref_mem[pa[win]] = pd[win];
        else rq.push_back('{due: n + 2, ch: win, data: ref_mem[pa[win]]});
        pv[win] = 1'b0;
        if (m == 1) ptr = (win + 1) % N;
      end
    end
    mode_a = 2'd0;

    do_reset();
    nxt();
    put_b(0, 1, 0, 9'd510, 0);
    smp();
    chk("oor_rd_ready", ib.req_ready_o, 3'b001);
    nxt();
    put_b(0, 1, 1, 9'd505, 32'hDEADBEEF);
    smp();
    chk("oor_rd_cenb", cenb_b, 1);
    chk("oor_err_set", err_b, 1);
    chk("oor_wr_ready", ib.req_ready_o, 3'b001);
    nxt();
    idle();
    smp();
    chk("oor_wr_cenb", cenb_b, 1);
    nxt();
    smp();
    chk("oor_rsp_early", ib.rsp_valid_o, 0);
    nxt();
    smp();
    chk("oor_rsp_valid", ib.rsp_valid_o, 3'b001);
    chk("oor_rsp_data", ib.rsp_data_o, 0);
    chk("oor_rsp_err", ib.rsp_err_o, 1);
    nxt();
    smp();
    chk("oor_rsp_done", ib.rsp_valid_o, 0);
    chk("oor_err_sticky", err_b, 1);
    chk("oor_wr_dropped", mem_b[505], 0);

    nxt();
    put_b(0, 1, 0, 9'd3, 0);
    smp();
    chk("lat3_ready", ib.req_ready_o, 3'b001);
    nxt();
    idle();
    nxt();
    rst = 1'b1;
    put_b(1, 1, 0, 9'd4, 0);
    smp();
    chk("lat3_rst_ready", ib.req_ready_o, 0);
    nxt();
    smp();
    chk("lat3_rst_cenb", cenb_b, 1);
    chk("lat3_rst_wenb", wenb_b, 1);
    chk("lat3_rst_addr", addr_b, 0);
    chk("lat3_rst_d", d_b, 0);
    chk("lat3_rst_err", err_b, 0);
    chk("lat3_rst_stall", stall_b, 0);
    chk("lat3_rst_rsp", {ib.rsp_valid_o, ib.rsp_err_o}, 0);
    nxt();
    rst = 1'b0;
    idle();
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("lat3_no_rsp", ib.rsp_valid_o, 0);
      nxt();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
